// File: rtl/bram_pkg.sv
// Shared definitions for the simple-dual-port byte-enable block RAM.
// Contents: FSM state encoding, legal read-latency bounds, per-lane merge helper.
package bram_pkg;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } bram_state_e;

    localparam int unsigned RDLAT_MIN = 1;
    localparam int unsigned RDLAT_MAX = 2;

    // One byte lane of a strobed write: the new byte where the strobe is set, else the old one.
    function automatic logic [7:0] byte_merge(input logic [7:0] old_byte,
                                              input logic [7:0] new_byte,
                                              input logic       strb);
        return strb ? new_byte : old_byte;
    endfunction

endpackage

// File: rtl/bram_sdp_be_if.sv
// Bus interface of bram_sdp_be.
//   master: user side, drives INITREQ/REN/RADDR/WEN/WADDR/WSTRB/DIN, sees DOUT/DVALID/INITBUSY
//   slave : RAM side
interface bram_sdp_be_if #(
    parameter int unsigned BRAMWIDE = 32,
    parameter int unsigned BRAMDEPW = 7
) ();
    localparam int unsigned NBYTE = BRAMWIDE / 8;

    logic                INITREQ;
    logic                REN;
    logic [BRAMDEPW-1:0] RADDR;
    logic                WEN;
    logic [BRAMDEPW-1:0] WADDR;
    logic [NBYTE-1:0]    WSTRB;
    logic [BRAMWIDE-1:0] DIN;
    logic [BRAMWIDE-1:0] DOUT;
    logic                DVALID;
    logic                INITBUSY;

    modport master (
        output INITREQ, REN, RADDR, WEN, WADDR, WSTRB, DIN,
        input  DOUT, DVALID, INITBUSY
    );

    modport slave (
        input  INITREQ, REN, RADDR, WEN, WADDR, WSTRB, DIN,
        output DOUT, DVALID, INITBUSY
    );
endinterface

// File: rtl/bram_init_seq.sv
// Clear-sweep sequencer: walks addresses 0..BRAMDEEP-1 writing zero, one word per cycle.
// Ports:
//   clk, rst   clock, asynchronous active-high reset (reset starts a sweep)
//   init_req   start a new sweep; only honoured while READY
//   init_we    sweep write strobe for the RAM write port
//   init_addr  sweep write address
//   init_busy  high while the sweep runs
module bram_init_seq
    import bram_pkg::*;
#(
    parameter int unsigned BRAMDEPW = 7,
    parameter int unsigned BRAMDEEP = 128
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                init_req,
    output logic                init_we,
    output logic [BRAMDEPW-1:0] init_addr,
    output logic                init_busy
);
    localparam logic [BRAMDEPW-1:0] LAST_ADDR = BRAMDEPW'(BRAMDEEP - 1);

    bram_state_e         state_q, state_d;
    logic [BRAMDEPW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_INIT: begin
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_READY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_READY: begin
                if (init_req) begin
                    state_d = ST_INIT;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    assign init_we   = (state_q == ST_INIT);
    assign init_addr = cnt_q;
    assign init_busy = init_we;

endmodule

// File: rtl/bram_sdp_be.sv
// Simple-dual-port block RAM with byte-lane write strobes, 1- or 2-cycle read latency with a
// valid flag, and a sequenced clear sweep after reset or on INITREQ.
// Ports:
//   Clk   sole clock, rising edge
//   Rest  asynchronous active-high reset
//   bus   bram_sdp_be_if.slave (INITREQ, REN/RADDR, WEN/WADDR/WSTRB/DIN, DOUT/DVALID/INITBUSY)
// Build option: define BRAM_BYPASS_EN to forward same-address write data to a colliding read
// (write-first); otherwise a colliding read returns the stored word (read-first).
module bram_sdp_be
    import bram_pkg::*;
#(
    parameter int unsigned BRAMWIDE = 32,
    parameter int unsigned BRAMDEPW = 7,
    parameter int unsigned BRAMDEEP = 128,
    parameter int unsigned RDLAT    = 1
) (
    input logic         Clk,
    input logic         Rest,
    bram_sdp_be_if.slave bus
);
    localparam int unsigned NBYTE = BRAMWIDE / 8;

    if (RDLAT < RDLAT_MIN || RDLAT > RDLAT_MAX) begin : g_bad_rdlat
        $error("bram_sdp_be: RDLAT must be 1 or 2");
    end
    if (BRAMWIDE % 8 != 0 || BRAMWIDE == 0) begin : g_bad_wide
        $error("bram_sdp_be: BRAMWIDE must be a non-zero multiple of 8");
    end
    if (BRAMDEEP < 1 || BRAMDEEP > (1 << BRAMDEPW)) begin : g_bad_deep
        $error("bram_sdp_be: BRAMDEEP must be in 1..2**BRAMDEPW");
    end

    logic                init_we, init_busy;
    logic [BRAMDEPW-1:0] init_addr;

    bram_init_seq #(
        .BRAMDEPW (BRAMDEPW),
        .BRAMDEEP (BRAMDEEP)
    ) u_init_seq (
        .clk       (Clk),
        .rst       (Rest),
        .init_req  (bus.INITREQ),
        .init_we   (init_we),
        .init_addr (init_addr),
        .init_busy (init_busy)
    );

    // A sweep in progress, or one being requested this cycle, kills every read in flight.
    logic flush, rd_acc, wr_acc, rd_in_range, wr_in_range;
    assign flush       = init_busy | bus.INITREQ;
    assign rd_in_range = 32'(bus.RADDR) < BRAMDEEP;
    assign wr_in_range = 32'(bus.WADDR) < BRAMDEEP;
    assign rd_acc      = bus.REN & ~flush;
    assign wr_acc      = bus.WEN & ~init_busy & wr_in_range & (|bus.WSTRB);

    logic [BRAMWIDE-1:0] mem [BRAMDEEP];
    logic [BRAMWIDE-1:0] wr_old, wr_merged, rd_word, rd_data;

    assign wr_old = mem[bus.WADDR];
    for (genvar k = 0; k < NBYTE; k++) begin : g_lane
        assign wr_merged[8*k +: 8] = byte_merge(wr_old[8*k +: 8], bus.DIN[8*k +: 8], bus.WSTRB[k]);
    end

    // Sweep owns the write port while it runs.
    logic                mem_we;
    logic [BRAMDEPW-1:0] mem_waddr;
    logic [BRAMWIDE-1:0] mem_wdata;
    assign mem_we    = init_we | wr_acc;
    assign mem_waddr = init_we ? init_addr : bus.WADDR;
    assign mem_wdata = init_we ? '0 : wr_merged;

    always_ff @(posedge Clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

`ifdef BRAM_BYPASS_EN
    // On a same-address write the merged word is exactly what the array will hold next.
    assign rd_word = (wr_acc && (bus.RADDR == bus.WADDR)) ? wr_merged : mem[bus.RADDR];
`else
    assign rd_word = mem[bus.RADDR];
`endif
    assign rd_data = rd_in_range ? rd_word : '0;

    logic [BRAMWIDE-1:0] d1_q;
    logic                v1_q;

    always_ff @(posedge Clk or posedge Rest) begin
        if (Rest) begin
            d1_q <= '0;
            v1_q <= 1'b0;
        end else begin
            v1_q <= rd_acc;
            if (rd_acc) begin
                d1_q <= rd_data;
            end
        end
    end

    if (RDLAT == 2) begin : g_lat2
        logic [BRAMWIDE-1:0] d2_q;
        logic                v2_q;

        always_ff @(posedge Clk or posedge Rest) begin
            if (Rest) begin
                d2_q <= '0;
                v2_q <= 1'b0;
            end else begin
                v2_q <= v1_q & ~flush;
                if (v1_q & ~flush) begin
                    d2_q <= d1_q;
                end
            end
        end

        assign bus.DOUT   = d2_q;
        assign bus.DVALID = v2_q;
    end else begin : g_lat1
        assign bus.DOUT   = d1_q;
        assign bus.DVALID = v1_q;
    end

    assign bus.INITBUSY = init_busy;

endmodule

// File: tb/tb_bram_sdp_be.sv
// Directed bench for bram_sdp_be. Three instances share one clock:
//   u_a: 128 words, RDLAT=1 (sweep, strobes, collision, reset mid-sweep)
//   u_b: 100 words, RDLAT=1 (out-of-range addresses)
//   u_c: 128 words, RDLAT=2 (pipelined burst, INITREQ flush)
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_bram_sdp_be;

    logic clk;
    logic rst;
    logic rst_a;
    int   n_checks = 0;
    int   n_fail   = 0;

`ifdef BRAM_BYPASS_EN
    localparam logic [31:0] EXP_COLL = 32'h1122CCDD;
`else
    localparam logic [31:0] EXP_COLL = 32'h11223344;
`endif

    bram_sdp_be_if #(.BRAMWIDE(32), .BRAMDEPW(7)) if_a ();
    bram_sdp_be_if #(.BRAMWIDE(32), .BRAMDEPW(7)) if_b ();
    bram_sdp_be_if #(.BRAMWIDE(32), .BRAMDEPW(7)) if_c ();

    bram_sdp_be #(.BRAMWIDE(32), .BRAMDEPW(7), .BRAMDEEP(128), .RDLAT(1)) u_a (
        .Clk (clk), .Rest (rst_a), .bus (if_a.slave)
    );
    bram_sdp_be #(.BRAMWIDE(32), .BRAMDEPW(7), .BRAMDEEP(100), .RDLAT(1)) u_b (
        .Clk (clk), .Rest (rst), .bus (if_b.slave)
    );
    bram_sdp_be #(.BRAMWIDE(32), .BRAMDEPW(7), .BRAMDEEP(128), .RDLAT(2)) u_c (
        .Clk (clk), .Rest (rst), .bus (if_c.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic a_write(input logic [6:0] addr, input logic [31:0] data, input logic [3:0] strb);
        if_a.WEN = 1'b1; if_a.WADDR = addr; if_a.DIN = data; if_a.WSTRB = strb;
        @(negedge clk);
        if_a.WEN = 1'b0;
    endtask

    task automatic a_read(input string tag, input logic [6:0] addr, input logic [31:0] exp);
        if_a.REN = 1'b1; if_a.RADDR = addr;
        @(negedge clk);
        if_a.REN = 1'b0;
        check_eq({tag, "_dv"}, 32'(if_a.DVALID), 32'd1);
        check_eq(tag, if_a.DOUT, exp);
    endtask

    task automatic b_write(input logic [6:0] addr, input logic [31:0] data);
        if_b.WEN = 1'b1; if_b.WADDR = addr; if_b.DIN = data; if_b.WSTRB = 4'hF;
        @(negedge clk);
        if_b.WEN = 1'b0;
    endtask

    task automatic b_read(input string tag, input logic [6:0] addr, input logic [31:0] exp);
        if_b.REN = 1'b1; if_b.RADDR = addr;
        @(negedge clk);
        if_b.REN = 1'b0;
        check_eq({tag, "_dv"}, 32'(if_b.DVALID), 32'd1);
        check_eq(tag, if_b.DOUT, exp);
    endtask

    task automatic c_write(input logic [6:0] addr, input logic [31:0] data);
        if_c.WEN = 1'b1; if_c.WADDR = addr; if_c.DIN = data; if_c.WSTRB = 4'hF;
        @(negedge clk);
        if_c.WEN = 1'b0;
    endtask

    task automatic c_read(input string tag, input logic [6:0] addr, input logic [31:0] exp);
        if_c.REN = 1'b1; if_c.RADDR = addr;
        @(negedge clk);
        if_c.REN = 1'b0;
        check_eq({tag, "_dv0"}, 32'(if_c.DVALID), 32'd0);
        @(negedge clk);
        check_eq({tag, "_dv"}, 32'(if_c.DVALID), 32'd1);
        check_eq(tag, if_c.DOUT, exp);
    endtask

    // Counts falling edges with INITBUSY high on u_a, starting at the current edge.
    task automatic a_count_busy(output int n, output int dv_seen);
        n = 0;
        dv_seen = 0;
        while (if_a.INITBUSY && n < 300) begin
            n++;
            if (if_a.DVALID) dv_seen++;
            @(negedge clk);
        end
    endtask

    function automatic logic [31:0] c_data(input int i);
        return 32'hC0DE0000 | 32'(i);
    endfunction

    int n_busy;
    int dv_seen;

    initial begin
        rst = 1'b0;
        rst_a = 1'b0;
        if_a.INITREQ = 0; if_a.REN = 0; if_a.RADDR = '0; if_a.WEN = 0; if_a.WADDR = '0;
        if_a.WSTRB = '0; if_a.DIN = '0;
        if_b.INITREQ = 0; if_b.REN = 0; if_b.RADDR = '0; if_b.WEN = 0; if_b.WADDR = '0;
        if_b.WSTRB = '0; if_b.DIN = '0;
        if_c.INITREQ = 0; if_c.REN = 0; if_c.RADDR = '0; if_c.WEN = 0; if_c.WADDR = '0;
        if_c.WSTRB = '0; if_c.DIN = '0;
        #2;
        rst = 1'b1;
        rst_a = 1'b1;
        @(negedge clk);

        // 1: reset values, sweep length, commands ignored during the sweep, read of cleared word
        check_eq("rst_dout", if_a.DOUT, 32'h0);
        check_eq("rst_dv", 32'(if_a.DVALID), 32'd0);
        check_eq("rst_busy", 32'(if_a.INITBUSY), 32'd1);
        rst = 1'b0;
        rst_a = 1'b0;
        if_a.REN = 1'b1; if_a.RADDR = 7'd5;
        if_a.WEN = 1'b1; if_a.WADDR = 7'd5; if_a.DIN = 32'hFFFFFFFF; if_a.WSTRB = 4'hF;
        a_count_busy(n_busy, dv_seen);
        if_a.REN = 1'b0;
        if_a.WEN = 1'b0;
        check_eq("t1_busy_cycles", 32'(n_busy), 32'd128);
        check_eq("t1_dv_in_init", 32'(dv_seen), 32'd0);
        check_eq("t1_dv_idle", 32'(if_a.DVALID), 32'd0);
        a_read("t1_rd5", 7'd5, 32'h0);
        @(negedge clk);
        check_eq("t1_dv_pulse", 32'(if_a.DVALID), 32'd0);
        check_eq("t1_dout_hold", if_a.DOUT, 32'h0);

        // 2: byte strobes
        a_write(7'd3, 32'h11223344, 4'hF);
        a_write(7'd3, 32'hAABBCCDD, 4'b0010);
        a_read("t2_rd3", 7'd3, 32'h1122CC44);
        a_write(7'd3, 32'h55555555, 4'h0);
        a_read("t2_nostrb", 7'd3, 32'h1122CC44);

        // 3: read/write collision
        a_write(7'd3, 32'h11223344, 4'hF);
        if_a.WEN = 1'b1; if_a.WADDR = 7'd3; if_a.DIN = 32'hAABBCCDD; if_a.WSTRB = 4'b0011;
        if_a.REN = 1'b1; if_a.RADDR = 7'd3;
        @(negedge clk);
        if_a.WEN = 1'b0;
        if_a.REN = 1'b0;
        check_eq("t3_coll_dv", 32'(if_a.DVALID), 32'd1);
        check_eq("t3_coll", if_a.DOUT, EXP_COLL);
        a_read("t3_after", 7'd3, 32'h1122CCDD);

        // 4: out-of-range addresses on a 100-word array
        check_eq("t4_busy", 32'(if_b.INITBUSY), 32'd0);
        b_write(7'd20, 32'h12345678);
        b_write(7'd120, 32'hDEADBEEF);
        b_read("t4_rd120", 7'd120, 32'h0);
        b_read("t4_rd20", 7'd20, 32'h12345678);

        // 5: RDLAT=2 burst, then a burst cut short by INITREQ
        check_eq("t5_busy", 32'(if_c.INITBUSY), 32'd0);
        for (int i = 0; i < 8; i++) c_write(7'(i), c_data(i));
        for (int k = 0; k <= 10; k++) begin
            check_eq("t5_burst_dv", 32'(if_c.DVALID), (k >= 2 && k <= 9) ? 32'd1 : 32'd0);
            if (k >= 2 && k <= 9) check_eq("t5_burst_data", if_c.DOUT, c_data(k - 2));
            if_c.REN = (k < 8);
            if_c.RADDR = 7'(k);
            @(negedge clk);
        end
        for (int k = 0; k <= 4; k++) begin
            check_eq("t5_flush_dv", 32'(if_c.DVALID), (k >= 2) ? 32'd1 : 32'd0);
            if (k >= 2) check_eq("t5_flush_data", if_c.DOUT, c_data(k - 2));
            if_c.REN = 1'b1;
            if_c.RADDR = 7'(k);
            if_c.INITREQ = (k == 4);
            @(negedge clk);
        end
        if_c.INITREQ = 1'b0;
        n_busy = 0;
        dv_seen = 0;
        while (if_c.INITBUSY && n_busy < 300) begin
            n_busy++;
            if (if_c.DVALID) dv_seen++;
            @(negedge clk);
        end
        if_c.REN = 1'b0;
        check_eq("t5_busy_cycles", 32'(n_busy), 32'd128);
        check_eq("t5_dv_suppressed", 32'(dv_seen), 32'd0);
        for (int i = 0; i < 8; i++) c_read("t5_cleared", 7'(i), 32'h0);

        // 6: reset in the middle of a sweep
        a_write(7'd127, 32'hFFFFFFFF, 4'hF);
        rst_a = 1'b1;
        @(negedge clk);
        check_eq("t6_rst_dout", if_a.DOUT, 32'h0);
        rst_a = 1'b0;
        repeat (60) @(negedge clk);
        check_eq("t6_busy60", 32'(if_a.INITBUSY), 32'd1);
        rst_a = 1'b1;
        @(negedge clk);
        check_eq("t6_busy_rst", 32'(if_a.INITBUSY), 32'd1);
        rst_a = 1'b0;
        a_count_busy(n_busy, dv_seen);
        check_eq("t6_busy_cycles", 32'(n_busy), 32'd128);
        a_read("t6_rd3", 7'd3, 32'h0);
        a_read("t6_rd127", 7'd127, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
